l2_cache_nway: RTL and testbench
================================

L2_CACHE_NWAY -- requirements
Module: l2_cache_nway

Interface
REQ-001 SHALL have parameter S_OFFSET, default 5: log2 line bytes; line = 8*2^S_OFFSET bits.
REQ-002 SHALL have parameter S_INDEX, default 4: log2 sets.
REQ-003 SHALL have parameter WAYS, default 4: associativity; power of two, 2..16.
REQ-004 SHALL have one clock and an asynchronous active-low reset, with these ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have these upstream ports:
- mem_read  input  1  read request.
- mem_write  input  1  write request.
- mem_address  input  32  byte address.
- mem_wdata256  input  LINE  write data.
- mem_byte_enable256  input  2^S_OFFSET  byte mask.
- mem_rdata256  output  LINE  read data.
- mem_resp  output  1  completion pulse.
REQ-006 SHALL have these downstream ports:
- pmem_read  output  1  line fill request.
- pmem_write  output  1  line writeback request.
- pmem_address  output  32  line address.
- pmem_wdata  output  LINE  writeback data.
- pmem_rdata  input  LINE  fill data.
- pmem_resp  input  1  downstream completion.

Function
REQ-007 SHALL be write-back, write-allocate, WAYS-way set-associative; tag = mem_address[31:S_OFFSET+S_INDEX], index = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET].
REQ-008 SHALL implement FSM states IDLE, COMPARE, WRITEBACK, ALLOCATE.
REQ-009 In IDLE with mem_read|mem_write, SHALL latch address, wdata, byte enable and op, then go to COMPARE; both asserted = write. Upstream changes are ignored until mem_resp.
REQ-010 In COMPARE, hit = tag match AND valid in exactly one way; on hit SHALL assert mem_resp for one cycle and return to IDLE.
- Read hit: mem_rdata256 = line.
- Write hit: merge bytes with enable=1, set dirty.
- Hit latency: request seen in IDLE cycle N, mem_resp in cycle N+1.
REQ-011 Victim SHALL be the lowest-index invalid way if any exists; otherwise the tree-PLRU way.
REQ-012 On miss, COMPARE SHALL go to WRITEBACK if the victim is valid and dirty, else to ALLOCATE.
REQ-013 WRITEBACK SHALL hold pmem_write=1, pmem_address={victim tag, index, 0}, pmem_wdata=victim line until pmem_resp, then go to ALLOCATE.
REQ-014 ALLOCATE SHALL hold pmem_read=1, pmem_address={req tag, index, 0} until pmem_resp.
- On pmem_resp: write pmem_rdata into the victim, tag=req tag, valid=1, dirty=0.
- Then go to COMPARE, which hits.
REQ-015 PLRU SHALL be one heap-ordered tree of WAYS-1 bits per set; node i has children 2i+1 and 2i+2; bit=0 means victim in left subtree.
REQ-016 Every hit in COMPARE SHALL set each node on the path to the accessed way to point away from it; misses update PLRU only via the following hit.
REQ-017 Outside the owning state, pmem_read, pmem_write, pmem_address and pmem_wdata SHALL be 0; mem_rdata256 SHALL be 0 except when mem_resp=1.
REQ-018 pmem_resp outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-019 Tag and data arrays SHALL be read combinationally and written on the clk edge.

Reset
REQ-020 rst=0 SHALL immediately force:
- FSM to IDLE.
- mem_resp, pmem_read and pmem_write to 0.
- All valid, dirty and PLRU bits to 0.
Tag and data arrays are not reset.
REQ-021 Reset mid-WRITEBACK/ALLOCATE SHALL abandon the transaction with no array update; the request is lost.

Configuration
REQ-022 With macro L2_PERF_CNT_EN defined, SHALL add outputs hit_count, miss_count and wb_count, each 32 bits:
- Increment on first-pass COMPARE hit, on COMPARE miss, and on WRITEBACK completion respectively.
- Saturate at 0xFFFFFFFF.
- Reset to 0.
REQ-023 Without L2_PERF_CNT_EN, counters and ports SHALL be absent and behaviour is otherwise identical.

Verification (S_OFFSET=5, S_INDEX=4, WAYS=4)
REQ-024 Reset, read 0x40 -> pmem_read, pmem_address=0x40; pmem_resp with line L -> next cycle COMPARE hit, mem_resp with mem_rdata256=L.
REQ-025 Write 0x40 with byte_enable=0x0000000F, data 0xAABBCCDD in bytes 0-3 after fill -> mem_resp in 1 cycle; subsequent read returns bytes 0-3 = 0xAABBCCDD, remaining bytes = L.
REQ-026 Cold reads 0x40, 0x240, 0x440, 0x640 -> fill ways 0,1,2,3; PLRU={root 0,n1 0,n2 0}; read 0x840 evicts way 0.
REQ-027 Same as REQ-026 but 0x40 written first -> read 0x840 gives pmem_write at 0x40 with merged line, then pmem_read at 0x840.
REQ-028 mem_read and mem_write both high -> treated as write, dirty set.
REQ-029 rst=0 during ALLOCATE -> pmem_read=0 at once; after release, read 0x40 misses again.
REQ-030 With L2_PERF_CNT_EN, REQ-027 sequence -> miss_count=6, wb_count=1, hit_count=1.

Source files
------------

// File: rtl/l2_cache_nway_if.sv
// Upstream request/response and downstream line-fill/writeback signals of the L2 cache.
// master = requester and memory side (drives mem_* requests and pmem responses), slave = cache.
interface l2_cache_nway_if #(
   parameter int unsigned S_OFFSET = 5
);
   localparam int unsigned LINE  = 8 << S_OFFSET;
   localparam int unsigned BYTES = 1 << S_OFFSET;

   logic             mem_read;
   logic             mem_write;
   logic [31:0]      mem_address;
   logic [LINE-1:0]  mem_wdata256;
   logic [BYTES-1:0] mem_byte_enable256;
   logic [LINE-1:0]  mem_rdata256;
   logic             mem_resp;
   logic             pmem_read;
   logic             pmem_write;
   logic [31:0]      pmem_address;
   logic [LINE-1:0]  pmem_wdata;
   logic [LINE-1:0]  pmem_rdata;
   logic             pmem_resp;

   modport master (
      output mem_read, mem_write, mem_address, mem_wdata256, mem_byte_enable256,
      input  mem_rdata256, mem_resp,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_rdata, pmem_resp
   );

   modport slave (
      input  mem_read, mem_write, mem_address, mem_wdata256, mem_byte_enable256,
      output mem_rdata256, mem_resp,
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/l2_cache_nway.sv
// Write-back, write-allocate, WAYS-way set-associative cache with per-set tree-PLRU.
// Define L2_PERF_CNT_EN to add saturating hit/miss/writeback counter outputs.
module l2_cache_nway #(
   parameter int unsigned S_OFFSET = 5,
   parameter int unsigned S_INDEX  = 4,
   parameter int unsigned WAYS     = 4
) (
   input logic            clk,
   input logic            rst,
   l2_cache_nway_if.slave bus
`ifdef L2_PERF_CNT_EN
   ,
   output logic [31:0]    hit_count,
   output logic [31:0]    miss_count,
   output logic [31:0]    wb_count
`endif
);
   localparam int unsigned LINE  = 8 << S_OFFSET;
   localparam int unsigned BYTES = 1 << S_OFFSET;
   localparam int unsigned SETS  = 1 << S_INDEX;
   localparam int unsigned TAG_W = 32 - S_OFFSET - S_INDEX;
   localparam int unsigned WAY_W = $clog2(WAYS);

   typedef enum logic [1:0] {StIdle, StCompare, StWriteback, StAllocate} state_e;

   state_e                       state_q, state_d;
   logic                         write_q, refill_q;
   logic [31-S_OFFSET:0]         line_addr_q;
   logic [LINE-1:0]              wdata_q;
   logic [BYTES-1:0]             be_q;
   logic [WAY_W-1:0]             victim_q;

   logic [TAG_W-1:0]             tag_q   [SETS][WAYS];
   logic [LINE-1:0]              data_q  [SETS][WAYS];
   logic [WAYS-1:0]              valid_q [SETS];
   logic [WAYS-1:0]              dirty_q [SETS];
   logic [WAYS-2:0]              plru_q  [SETS];

   logic [TAG_W-1:0]             req_tag;
   logic [S_INDEX-1:0]           idx;
   logic [WAYS-1:0]              hit_vec;
   logic                         hit;
   logic [WAY_W-1:0]             hit_way, victim;
   logic [LINE-1:0]              hit_line, merged;
   logic                         fill_we, hit_we, miss, wb_done;

   assign req_tag  = line_addr_q[31-S_OFFSET -: TAG_W];
   assign idx      = line_addr_q[S_INDEX-1:0];
   assign hit_line = data_q[idx][hit_way];

   always_comb begin
      hit_vec = '0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == req_tag);
         if (hit_vec[w]) hit_way = WAY_W'(w);
      end
      hit = $onehot(hit_vec);
   end

   // Lowest invalid way wins over the PLRU walk.
   always_comb begin
      int unsigned node;
      node = 0;
      for (int l = 0; l < WAY_W; l++) node = plru_q[idx][node] ? 2 * node + 2 : 2 * node + 1;
      victim = WAY_W'(node - (WAYS - 1));
      for (int w = WAYS - 1; w >= 0; w--) if (!valid_q[idx][w]) victim = WAY_W'(w);
   end

   always_comb begin
      merged = hit_line;
      for (int b = 0; b < BYTES; b++) if (be_q[b]) merged[b*8 +: 8] = wdata_q[b*8 +: 8];
   end

   // Every node on the path to the touched way points to the opposite subtree.
   function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] tree,
                                                  input logic [WAY_W-1:0] way);
      logic [WAYS-2:0] t;
      int unsigned     node, parent;
      t    = tree;
      node = int'(way) + WAYS - 1;
      for (int l = 0; l < WAY_W; l++) begin
         parent    = (node - 1) / 2;
         t[parent] = node[0];
         node      = parent;
      end
      return t;
   endfunction

   always_comb begin
      state_d           = state_q;
      bus.mem_resp      = 1'b0;
      bus.mem_rdata256  = '0;
      bus.pmem_read     = 1'b0;
      bus.pmem_write    = 1'b0;
      bus.pmem_address  = '0;
      bus.pmem_wdata    = '0;
      fill_we           = 1'b0;
      hit_we            = 1'b0;
      miss              = 1'b0;
      wb_done           = 1'b0;
      case (state_q)
         StIdle: if (bus.mem_read || bus.mem_write) state_d = StCompare;
         StCompare: begin
            if (hit) begin
               bus.mem_resp     = 1'b1;
               bus.mem_rdata256 = hit_line;
               hit_we           = write_q;
               state_d          = StIdle;
            end else begin
               miss    = 1'b1;
               state_d = (valid_q[idx][victim] && dirty_q[idx][victim]) ? StWriteback : StAllocate;
            end
         end
         StWriteback: begin
            bus.pmem_write   = 1'b1;
            bus.pmem_address = {tag_q[idx][victim_q], idx, {S_OFFSET{1'b0}}};
            bus.pmem_wdata   = data_q[idx][victim_q];
            if (bus.pmem_resp) begin
               wb_done = 1'b1;
               state_d = StAllocate;
            end
         end
         StAllocate: begin
            bus.pmem_read    = 1'b1;
            bus.pmem_address = {line_addr_q, {S_OFFSET{1'b0}}};
            if (bus.pmem_resp) begin
               fill_we = 1'b1;
               state_d = StCompare;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         write_q     <= 1'b0;
         refill_q    <= 1'b0;
         line_addr_q <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         victim_q    <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && (bus.mem_read || bus.mem_write)) begin
            line_addr_q <= bus.mem_address[31:S_OFFSET];
            wdata_q     <= bus.mem_wdata256;
            be_q        <= bus.mem_byte_enable256;
            write_q     <= bus.mem_write;
            refill_q    <= 1'b0;
         end
         if (miss) victim_q <= victim;
         if (bus.mem_resp) plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
         if (hit_we) dirty_q[idx][hit_way] <= 1'b1;
         if (fill_we) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
            refill_q               <= 1'b1;
         end
      end
   end

   // Tag/data storage carries no reset; valid bits gate its use.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag_q[idx][victim_q]  <= req_tag;
         data_q[idx][victim_q] <= bus.pmem_rdata;
      end else if (hit_we) begin
         data_q[idx][hit_way] <= merged;
      end
   end

`ifdef L2_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         if (bus.mem_resp && !refill_q && hit_count != '1) hit_count <= hit_count + 32'd1;
         if (miss && miss_count != '1) miss_count <= miss_count + 32'd1;
         if (wb_done && wb_count != '1) wb_count <= wb_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_l2_cache_nway.sv
// Directed bench for l2_cache_nway (S_OFFSET=5, S_INDEX=4, WAYS=4); with L2_PERF_CNT_EN
// defined it also checks the performance counters.
module tb_l2_cache_nway;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   passes = 0;
   int   fails  = 0;

   l2_cache_nway_if #(.S_OFFSET(5)) bus ();

`ifdef L2_PERF_CNT_EN
   logic [31:0] hit_count, miss_count, wb_count;
`endif

   l2_cache_nway #(.S_OFFSET(5), .S_INDEX(4), .WAYS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus)
`ifdef L2_PERF_CNT_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count),
      .wb_count   (wb_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] mk_line(input logic [31:0] a);
      return {8{a ^ 32'hA5A5_0000}};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      assert (got === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [255:0] wd, input logic [31:0] be);
      bus.mem_read           = rd;
      bus.mem_write          = wr;
      bus.mem_address        = a;
      bus.mem_wdata256       = wd;
      bus.mem_byte_enable256 = be;
      step();
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
   endtask

   // Ends in the COMPARE cycle after the fill, where the request must hit.
   task automatic miss_fill(input string tag, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [255:0] wd,
                            input logic [31:0] be, input logic [255:0] line);
      issue(rd, wr, a, wd, be);
      chk({tag, "_miss"}, bus.mem_resp, 0);
      step();
      chk({tag, "_pread"}, bus.pmem_read, 1);
      chk({tag, "_paddr"}, bus.pmem_address, a);
      bus.pmem_rdata = line;
      bus.pmem_resp  = 1'b1;
      step();
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      chk({tag, "_resp"}, bus.mem_resp, 1);
   endtask

   task automatic read_hit(input string tag, input logic [31:0] a, input logic [255:0] exp);
      issue(1'b1, 1'b0, a, '0, '0);
      chk({tag, "_resp"}, bus.mem_resp, 1);
      chk({tag, "_rdata"}, bus.mem_rdata256, exp);
      step();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
   endtask

   logic [255:0] l40, l240, l440, l640, l840, wd, merged;

   initial begin
      l40    = mk_line(32'h40);
      l240   = mk_line(32'h240);
      l440   = mk_line(32'h440);
      l640   = mk_line(32'h640);
      l840   = mk_line(32'h840);
      wd     = {{7{32'hDEAD_BEEF}}, 32'hAABB_CCDD};
      merged = {l40[255:32], 32'hAABB_CCDD};
      bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_address = '0;
      bus.mem_wdata256 = '0; bus.mem_byte_enable256 = '0;
      bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;

      #2;
      chk("rst_mem_resp", bus.mem_resp, 0);
      chk("rst_pmem_read", bus.pmem_read, 0);
      chk("rst_pmem_write", bus.pmem_write, 0);
      step();
      rst = 1'b1;
      step();

      // Cold read, fill, hit; then a byte-masked write hit and read-back.
      issue(1'b1, 1'b0, 32'h40, '0, '0);
      chk("cold_miss_resp", bus.mem_resp, 0);
      chk("cold_rdata_zero", bus.mem_rdata256, 0);
      chk("cold_no_pread_in_cmp", bus.pmem_read, 0);
      step();
      chk("alloc_pread", bus.pmem_read, 1);
      chk("alloc_paddr", bus.pmem_address, 32'h40);
      chk("alloc_no_pwrite", bus.pmem_write, 0);
      step();
      chk("alloc_hold", bus.pmem_read, 1);
      bus.pmem_rdata = l40;
      bus.pmem_resp  = 1'b1;
      step();
      bus.pmem_resp  = 1'b0;
      chk("fill_hit_resp", bus.mem_resp, 1);
      chk("fill_hit_rdata", bus.mem_rdata256, l40);
      chk("fill_pread_low", bus.pmem_read, 0);
      chk("fill_paddr_zero", bus.pmem_address, 0);
      step();
      chk("idle_resp_low", bus.mem_resp, 0);
      issue(1'b0, 1'b1, 32'h40, wd, 32'h0000_000F);
      chk("wr_hit_resp", bus.mem_resp, 1);
      step();
      read_hit("rd_merged", 32'h40, merged);

      // Fill all four ways of set 2, then evict way 0 via PLRU.
      do_reset();
      miss_fill("c40", 1'b1, 1'b0, 32'h40, '0, '0, l40);
      chk("c40_rdata", bus.mem_rdata256, l40);
      step();
      miss_fill("c240", 1'b1, 1'b0, 32'h240, '0, '0, l240);
      step();
      miss_fill("c440", 1'b1, 1'b0, 32'h440, '0, '0, l440);
      step();
      miss_fill("c640", 1'b1, 1'b0, 32'h640, '0, '0, l640);
      chk("c640_rdata", bus.mem_rdata256, l640);
      step();
      miss_fill("c840", 1'b1, 1'b0, 32'h840, '0, '0, l840);
      chk("c840_rdata", bus.mem_rdata256, l840);
      step();
      read_hit("keep240", 32'h240, l240);
      miss_fill("evicted40", 1'b1, 1'b0, 32'h40, '0, '0, l40);
      step();

      // Read+write together on a cold line acts as a write; eviction writes it back.
      do_reset();
      miss_fill("rw40", 1'b1, 1'b1, 32'h40, wd, 32'h0000_000F, l40);
      step();
      read_hit("rw_merged", 32'h40, merged);
      miss_fill("d240", 1'b1, 1'b0, 32'h240, '0, '0, l240);
      step();
      miss_fill("d440", 1'b1, 1'b0, 32'h440, '0, '0, l440);
      step();
      miss_fill("d640", 1'b1, 1'b0, 32'h640, '0, '0, l640);
      step();
      issue(1'b1, 1'b0, 32'h840, '0, '0);
      chk("d840_miss", bus.mem_resp, 0);
      step();
      chk("wb_pwrite", bus.pmem_write, 1);
      chk("wb_paddr", bus.pmem_address, 32'h40);
      chk("wb_pwdata", bus.pmem_wdata, merged);
      chk("wb_no_pread", bus.pmem_read, 0);
      step();
      chk("wb_hold", bus.pmem_write, 1);
      bus.pmem_resp = 1'b1;
      step();
      bus.pmem_resp = 1'b0;
      chk("wb_done_pwrite", bus.pmem_write, 0);
      chk("wb_alloc_pread", bus.pmem_read, 1);
      chk("wb_alloc_paddr", bus.pmem_address, 32'h840);
      bus.pmem_rdata = l840;
      bus.pmem_resp  = 1'b1;
      step();
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      chk("d840_resp", bus.mem_resp, 1);
      chk("d840_rdata", bus.mem_rdata256, l840);
      step();
      miss_fill("refetch40", 1'b1, 1'b0, 32'h40, '0, '0, merged);
      chk("refetch40_rdata", bus.mem_rdata256, merged);
      step();
`ifdef L2_PERF_CNT_EN
      chk("miss_count", miss_count, 6);
      chk("wb_count", wb_count, 1);
      chk("hit_count", hit_count, 1);
`endif

      // Reset during ALLOCATE abandons the fill and clears valid state.
      issue(1'b1, 1'b0, 32'h100, '0, '0);
      step();
      chk("pre_rst_pread", bus.pmem_read, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_pread", bus.pmem_read, 0);
      chk("mid_rst_pwrite", bus.pmem_write, 0);
      chk("mid_rst_resp", bus.mem_resp, 0);
      step();
      rst = 1'b1;
      step();
      miss_fill("post_rst40", 1'b1, 1'b0, 32'h40, '0, '0, merged);
      step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
